serial_adder_digit_addsub: RTL and testbench
============================================

Name: serial_adder_digit_addsub

Overview:
- Parametrised digit-serial adder/subtractor, successor to the 1-bit serial adder in the sequential-basics set.
- Adds or subtracts two word-framed operand streams, DIGIT_W bits per cycle, least-significant digit first; a word is WORD_DIGITS digits.
- Carry is kept between digits; streams may stall with in_valid gaps; outputs are registered and word-framed, with carry-out and signed overflow at the end of each word.
- Used wherever wide operands arrive serially (bit-serial datapaths, serial-link arithmetic).

Parameters:
- DIGIT_W, 1, bits per digit processed each cycle (>=1).
- WORD_DIGITS, 8, digits per word (>=1); word width = DIGIT_W*WORD_DIGITS.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low (0 = reset).
- in_valid  input  1  a, b, sub, in_first are valid this cycle.
- in_first  input  1  this digit is the LSD of a new word.
- sub  input  1  1 = a-b, 0 = a+b; sampled only at word start.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- out_valid  output  1  sum and flags valid.
- sum  output  DIGIT_W  result digit.
- out_last  output  1  sum is the MSD of the word.
- carry_out  output  1  carry out of this digit (for subtraction, 1 = no borrow).
- overflow  output  1  signed overflow; meaningful only with out_last (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge): out_valid, sum, out_last, carry_out, overflow = 0; carry_q = 0; sub_q = 0; cnt_q = 0.
- Word start: in_valid & (in_first | cnt_q==0). At word start the effective count is 0, sub_eff = sub (latched into sub_q), and carry_in = sub. Otherwise carry_in = carry_q and sub_eff = sub_q.
- Adder datapath: b_eff = b ^ {DIGIT_W{sub_eff}}. Each bit is a full adder built only from ^ & | ~ (s = x^y^c; c' = x&y | c&(x^y)), rippled LSB to MSB within the digit. No + or - operators.
- Accepted digit (in_valid==1): next posedge gives out_valid=1, sum = digit result, carry_out = digit carry, out_last = (cnt_eff==WORD_DIGITS-1). carry_q <= digit carry. cnt_q <= (cnt_eff==WORD_DIGITS-1) ? 0 : cnt_eff+1.
- Latency: 1 cycle, in to out. Throughput: 1 digit per cycle. No backpressure.
- Gap (in_valid==0): out_valid <= 0; out_last, carry_out and overflow <= 0; sum holds; carry_q, sub_q and cnt_q hold. The word resumes seamlessly.
- in_first while mid-word: the current word is aborted with no out_last for it. The new word starts at count 0 with fresh carry and sub.
- sub changes mid-word: ignored until the next word start.
- WORD_DIGITS==1: every accepted digit is a word start and has out_last=1.
- Reset mid-word: the partial word is discarded. The first accepted digit after reset is a word start.
- cnt_q width: $clog2(WORD_DIGITS) bits, minimum 1. Wrap from WORD_DIGITS-1 to 0 exactly.

Optional Feature:
- Macro: SERIAL_ADDER_OVERFLOW_EN.
- Defined: on a digit with out_last, overflow <= carry into the MSB of the digit ^ carry out of the MSB (two's-complement overflow of the whole word). On all other digits overflow <= 0.
- Undefined: the overflow port is still present but tied to 0. No overflow logic is generated.

Test Plan:
- DIGIT_W=1, WORD_DIGITS=8, sub=0: a=8'h3C, b=8'h0F sent LSB first with in_first on bit 0 -> sum bits form 8'h4B; out_last on the 8th output only; carry_out=0 on last; overflow=0.
- DIGIT_W=1, sub=1: 8'h05 - 8'h07 -> 8'hFE; carry_out=0 on last (borrow); overflow=0. Then 8'h80 - 8'h01 -> 8'h7F; overflow=1 with macro, 0 without.
- DIGIT_W=4, WORD_DIGITS=2, sub=0: 8'h7F + 8'h01 -> digits 4'h0, 4'h8; out_last on the 2nd digit; carry_out=0; overflow=1 (macro). Then 8'hFF + 8'h01 -> 4'h0, 4'h0; carry_out=1; overflow=0.
- Gaps: 8'h3C + 8'h0F (DIGIT_W=1) with in_valid low for 3 cycles after bits 2 and 5 -> same 8'h4B; out_valid low exactly in the gap cycles; out_last once.
- Abort: in_first reasserted after 3 bits of a word, then a full word 8'h01 + 8'h01 -> no out_last for the aborted word; new result 8'h02.
- Reset: rst=0 for 1 cycle mid-word -> all outputs 0 next cycle. A following word 8'hAA + 8'h55 with no in_first gives 8'hFF; the word starts implicitly at count 0.

Source files
------------

// File: rtl/serial_adder_digit_addsub.sv
// Purpose : digit-serial adder/subtractor, LSD first, word-framed, carry kept across digits.
// Latency : 1 cycle from accepted input digit to registered output digit; 1 digit per cycle.
// Backpr. : none; in_valid gaps stall the word (state holds) and drop out_valid.
//
// Ports:
//   clk, rst        clock (posedge) and synchronous active-low reset
//   in_valid        a, b, sub, in_first are valid this cycle
//   in_first        this digit is the LSD of a new word (aborts any word in progress)
//   sub             1 = a-b, 0 = a+b; only sampled at a word start
//   a, b            operand digits, DIGIT_W bits
//   out_valid       sum/flags valid
//   sum             result digit
//   out_last        sum is the MSD of its word
//   carry_out       carry out of this digit (subtraction: 1 = no borrow)
//   overflow        signed overflow of the whole word, only on the out_last digit
//
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN (overflow logic generated only when defined;
// otherwise the overflow port is tied to 0).
module serial_adder_digit_addsub #(
   parameter int DIGIT_W     = 1,
   parameter int WORD_DIGITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_first,
   input  logic               sub,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output logic               out_valid,
   output logic [DIGIT_W-1:0] sum,
   output logic               out_last,
   output logic               carry_out,
   output logic               overflow
);

   localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

   // Word-tracking state
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               sub_q, sub_d;

   // Output registers
   logic               out_valid_q, out_valid_d;
   logic [DIGIT_W-1:0] sum_q, sum_d;
   logic               out_last_q, out_last_d;
   logic               carry_out_q, carry_out_d;

   // Datapath
   logic               word_start;
   logic [CNT_W-1:0]   cnt_eff;
   logic               sub_eff;
   logic               is_last;
   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W-1:0] dsum;
   logic [DIGIT_W:0]   c;

   // A digit arriving at count 0 starts a word even without in_first, so
   // back-to-back words and the first word after reset need no marker.
   assign word_start = in_valid & (in_first | (cnt_q == '0));
   assign cnt_eff    = word_start ? '0 : cnt_q;
   assign sub_eff    = word_start ? sub : sub_q;
   assign is_last    = (cnt_eff == LAST_CNT);
   assign b_eff      = b ^ {DIGIT_W{sub_eff}};

   // Ripple of explicit full adders; for subtraction the word's initial
   // carry of 1 completes the two's-complement negation of b.
   always_comb begin
      c    = '0;
      dsum = '0;
      c[0] = word_start ? sub : carry_q;
      for (int i = 0; i < DIGIT_W; i++) begin
         dsum[i]  = a[i] ^ b_eff[i] ^ c[i];
         c[i + 1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      sub_d       = sub_q;
      out_valid_d = 1'b0;
      sum_d       = sum_q;
      out_last_d  = 1'b0;
      carry_out_d = 1'b0;
      if (in_valid) begin
         cnt_d       = is_last ? '0 : cnt_eff + CNT_W'(1);
         carry_d     = c[DIGIT_W];
         sub_d       = sub_eff;
         out_valid_d = 1'b1;
         sum_d       = dsum;
         out_last_d  = is_last;
         carry_out_d = c[DIGIT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         sub_q       <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         out_last_q  <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         sub_q       <= sub_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         out_last_q  <= out_last_d;
         carry_out_q <= carry_out_d;
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // Signed overflow: carry into the word's MSB differs from carry out of it.
   assign overflow_d = in_valid & is_last & (c[DIGIT_W-1] ^ c[DIGIT_W]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign out_last  = out_last_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_digit_addsub.sv
// Bench for serial_adder_digit_addsub: a bit-serial instance (1x8) and a nibble instance (4x2).
// Inputs change on negedge; outputs are sampled 1 time unit after the posedge that registers them.
// Expected values are hand-computed constants.
module tb_serial_adder_digit_addsub;

`ifdef SERIAL_ADDER_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // bit-serial instance
   logic       v1 = 0, f1 = 0, s1 = 0;
   logic [0:0] a1 = 0, b1 = 0;
   logic       ov1_valid, ov1_last, ov1_cout, ov1_ovf;
   logic [0:0] ov1_sum;
   logic       o1_v, o1_last, o1_cout, o1_ovf;
   logic [0:0] o1_sum;

   // nibble instance
   logic       v4 = 0, f4 = 0, s4 = 0;
   logic [3:0] a4 = 0, b4 = 0;
   logic       ov4_valid, ov4_last, ov4_cout, ov4_ovf;
   logic [3:0] ov4_sum;
   logic       o4_v, o4_last, o4_cout, o4_ovf;
   logic [3:0] o4_sum;

   serial_adder_digit_addsub #(.DIGIT_W(1), .WORD_DIGITS(8)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_first(f1), .sub(s1), .a(a1), .b(b1),
      .out_valid(ov1_valid), .sum(ov1_sum), .out_last(ov1_last),
      .carry_out(ov1_cout), .overflow(ov1_ovf));

   serial_adder_digit_addsub #(.DIGIT_W(4), .WORD_DIGITS(2)) u4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_first(f4), .sub(s4), .a(a4), .b(b4),
      .out_valid(ov4_valid), .sum(ov4_sum), .out_last(ov4_last),
      .carry_out(ov4_cout), .overflow(ov4_ovf));

   // One cycle on the bit-serial instance; called at a negedge, returns at the next negedge.
   task automatic cyc1(input logic v, input logic f, input logic s, input logic av, input logic bv);
      v1 = v; f1 = f; s1 = s; a1 = av; b1 = bv;
      @(posedge clk); #1;
      o1_v = ov1_valid; o1_sum = ov1_sum; o1_last = ov1_last;
      o1_cout = ov1_cout; o1_ovf = ov1_ovf;
      @(negedge clk);
      v1 = 0; f1 = 0;
   endtask

   task automatic cyc4(input logic v, input logic f, input logic s, input logic [3:0] av, input logic [3:0] bv);
      v4 = v; f4 = f; s4 = s; a4 = av; b4 = bv;
      @(posedge clk); #1;
      o4_v = ov4_valid; o4_sum = ov4_sum; o4_last = ov4_last;
      o4_cout = ov4_cout; o4_ovf = ov4_ovf;
      @(negedge clk);
      v4 = 0; f4 = 0;
   endtask

   // Sends one 8-bit word LSB first on the bit-serial instance, optionally with 3 idle
   // cycles after bit gap_a and bit gap_b, and gathers what came out.
   task automatic word1(input logic [7:0] av, input logic [7:0] bv, input logic s,
                        input logic use_first, input int gap_a, input int gap_b,
                        output logic [7:0] sv, output int nlast, output int lastpos,
                        output logic cout, output logic ovf, output int badv);
      sv = '0; nlast = 0; lastpos = -1; cout = 0; ovf = 0; badv = 0;
      for (int i = 0; i < 8; i++) begin
         cyc1(1'b1, use_first && (i == 0), s, av[i], bv[i]);
         sv[i] = o1_sum[0];
         if (!o1_v) badv++;
         if (o1_last) begin
            nlast++; lastpos = i; cout = o1_cout; ovf = o1_ovf;
         end
         if (i == gap_a || i == gap_b) begin
            for (int g = 0; g < 3; g++) begin
               cyc1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               if (o1_v || o1_last || o1_cout || o1_ovf) badv++;
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 0;
      repeat (2) @(negedge clk);
      #0;
      n_cmp++;
      if ({ov1_valid, ov1_sum, ov1_last, ov1_cout, ov1_ovf} !== 5'b0) begin
         n_err++; $display("FAIL reset_u1 got %b want 00000", {ov1_valid, ov1_sum, ov1_last, ov1_cout, ov1_ovf});
      end
      n_cmp++;
      if ({ov4_valid, ov4_sum, ov4_last, ov4_cout, ov4_ovf} !== 8'b0) begin
         n_err++; $display("FAIL reset_u4 got %b want 00000000", {ov4_valid, ov4_sum, ov4_last, ov4_cout, ov4_ovf});
      end
      rst = 1;
      @(negedge clk);
   endtask

   task automatic test_add;
      logic [7:0] sv; int nl, lp, bad; logic co, ov;
      word1(8'h3C, 8'h0F, 1'b0, 1'b1, -1, -1, sv, nl, lp, co, ov, bad);
      n_cmp++; if (sv !== 8'h4B) begin n_err++; $display("FAIL add_sum got %h want 4b", sv); end
      n_cmp++; if (nl !== 1 || lp !== 7) begin n_err++; $display("FAIL add_last got n=%0d pos=%0d want n=1 pos=7", nl, lp); end
      n_cmp++; if (co !== 1'b0 || ov !== 1'b0) begin n_err++; $display("FAIL add_flags got c=%b o=%b want c=0 o=0", co, ov); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL add_valid got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_sub;
      logic [7:0] sv; int nl, lp, bad; logic co, ov;
      word1(8'h05, 8'h07, 1'b1, 1'b1, -1, -1, sv, nl, lp, co, ov, bad);
      n_cmp++; if (sv !== 8'hFE) begin n_err++; $display("FAIL sub1_sum got %h want fe", sv); end
      n_cmp++; if (co !== 1'b0 || ov !== 1'b0 || nl !== 1) begin
         n_err++; $display("FAIL sub1_flags got c=%b o=%b n=%0d want c=0 o=0 n=1", co, ov, nl); end
      word1(8'h80, 8'h01, 1'b1, 1'b1, -1, -1, sv, nl, lp, co, ov, bad);
      n_cmp++; if (sv !== 8'h7F) begin n_err++; $display("FAIL sub2_sum got %h want 7f", sv); end
      n_cmp++; if (co !== 1'b1 || ov !== OVF_EN || lp !== 7) begin
         n_err++; $display("FAIL sub2_flags got c=%b o=%b pos=%0d want c=1 o=%b pos=7", co, ov, lp, OVF_EN); end
   endtask

   // Second word follows without in_first: it starts from count 0 and samples its own sub.
   task automatic test_back_to_back;
      logic [7:0] sv; int nl, lp, bad; logic co, ov;
      word1(8'h3C, 8'h0F, 1'b0, 1'b1, -1, -1, sv, nl, lp, co, ov, bad);
      word1(8'h05, 8'h07, 1'b1, 1'b0, -1, -1, sv, nl, lp, co, ov, bad);
      n_cmp++; if (sv !== 8'hFE || nl !== 1 || lp !== 7 || co !== 1'b0) begin
         n_err++; $display("FAIL b2b got sum=%h n=%0d pos=%0d c=%b want fe 1 7 0", sv, nl, lp, co); end
   endtask

   task automatic test_digit4;
      // 7F + 01 -> digits 0, 8; carry 0; signed overflow
      cyc4(1'b1, 1'b1, 1'b0, 4'hF, 4'h1);
      n_cmp++; if (o4_v !== 1'b1 || o4_sum !== 4'h0 || o4_last !== 1'b0 || o4_cout !== 1'b1) begin
         n_err++; $display("FAIL d4a_lo got v=%b s=%h l=%b c=%b want 1 0 0 1", o4_v, o4_sum, o4_last, o4_cout); end
      cyc4(1'b1, 1'b0, 1'b0, 4'h7, 4'h0);
      n_cmp++; if (o4_sum !== 4'h8 || o4_last !== 1'b1 || o4_cout !== 1'b0 || o4_ovf !== OVF_EN) begin
         n_err++; $display("FAIL d4a_hi got s=%h l=%b c=%b o=%b want 8 1 0 %b", o4_sum, o4_last, o4_cout, o4_ovf, OVF_EN); end
      // FF + 01 -> digits 0, 0; carry 1; no overflow. sub raised mid-word must be ignored.
      cyc4(1'b1, 1'b1, 1'b0, 4'hF, 4'h1);
      n_cmp++; if (o4_sum !== 4'h0 || o4_last !== 1'b0 || o4_ovf !== 1'b0) begin
         n_err++; $display("FAIL d4b_lo got s=%h l=%b o=%b want 0 0 0", o4_sum, o4_last, o4_ovf); end
      cyc4(1'b1, 1'b0, 1'b1, 4'hF, 4'h0);
      n_cmp++; if (o4_sum !== 4'h0 || o4_last !== 1'b1 || o4_cout !== 1'b1 || o4_ovf !== 1'b0) begin
         n_err++; $display("FAIL d4b_hi got s=%h l=%b c=%b o=%b want 0 1 1 0", o4_sum, o4_last, o4_cout, o4_ovf); end
      // Gap cycle: valid and flags drop, sum holds.
      cyc4(1'b0, 1'b0, 1'b0, 4'h3, 4'h3);
      n_cmp++; if (o4_v !== 1'b0 || o4_last !== 1'b0 || o4_cout !== 1'b0 || o4_sum !== 4'h0) begin
         n_err++; $display("FAIL d4_gap got v=%b l=%b c=%b s=%h want 0 0 0 0", o4_v, o4_last, o4_cout, o4_sum); end
   endtask

   task automatic test_gaps;
      logic [7:0] sv; int nl, lp, bad; logic co, ov;
      word1(8'h3C, 8'h0F, 1'b0, 1'b1, 2, 5, sv, nl, lp, co, ov, bad);
      n_cmp++; if (sv !== 8'h4B) begin n_err++; $display("FAIL gap_sum got %h want 4b", sv); end
      n_cmp++; if (nl !== 1 || bad !== 0) begin
         n_err++; $display("FAIL gap_frame got n_last=%0d bad=%0d want 1 0", nl, bad); end
   endtask

   task automatic test_abort;
      logic [7:0] sv; int nl, lp, bad; logic co, ov;
      int early_last;
      early_last = 0;
      // FF+FF leaves carry 1 and count 3 behind; the next word must ignore both.
      for (int i = 0; i < 3; i++) begin
         cyc1(1'b1, i == 0, 1'b0, 1'b1, 1'b1);
         if (o1_last) early_last++;
      end
      word1(8'h01, 8'h01, 1'b0, 1'b1, -1, -1, sv, nl, lp, co, ov, bad);
      n_cmp++; if (early_last !== 0) begin n_err++; $display("FAIL abort_nolast got %0d want 0", early_last); end
      n_cmp++; if (sv !== 8'h02 || nl !== 1 || lp !== 7) begin
         n_err++; $display("FAIL abort_word got sum=%h n=%0d pos=%0d want 02 1 7", sv, nl, lp); end
   endtask

   task automatic test_reset_midword;
      logic [7:0] sv; int nl, lp, bad; logic co, ov;
      for (int i = 0; i < 3; i++) cyc1(1'b1, i == 0, 1'b0, 1'b1, 1'b0);
      rst = 0;
      cyc1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if ({o1_v, o1_sum, o1_last, o1_cout, o1_ovf} !== 5'b0) begin
         n_err++; $display("FAIL rst_mid got %b want 00000", {o1_v, o1_sum, o1_last, o1_cout, o1_ovf}); end
      rst = 1;
      word1(8'hAA, 8'h55, 1'b0, 1'b0, -1, -1, sv, nl, lp, co, ov, bad);
      n_cmp++; if (sv !== 8'hFF || nl !== 1 || lp !== 7 || co !== 1'b0 || ov !== 1'b0) begin
         n_err++; $display("FAIL rst_word got sum=%h n=%0d pos=%0d c=%b o=%b want ff 1 7 0 0", sv, nl, lp, co, ov); end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_add;
      test_sub;
      test_back_to_back;
      test_digit4;
      test_gaps;
      test_abort;
      test_reset_midword;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
